// File: rtl/adsr_pkg.sv
// Shared types and constants for the ADSR envelope sequencer: phase encodings,
// envelope width/ceiling and the sustain-level scaling.
package adsr_pkg;

    localparam int ENV_W = 8;
    localparam logic [ENV_W-1:0] ENV_MAX = 8'd255;
    localparam int SUS_SCALE = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } state_t;

    // Sustain target on the 9-bit arithmetic grid (0..240 for a 4-bit level).
    function automatic logic [ENV_W:0] sus_target(input logic [3:0] lvl);
        return (ENV_W+1)'(32'(lvl) * SUS_SCALE);
    endfunction

endpackage

// File: rtl/gate_sync.sv
// Two-flop synchronizer for the asynchronous gate pin, followed by a registered
// rise/fall detector; edges appear three clocks after the pin changes.
module gate_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic sync1_reg, sync2_reg, prev_reg, rise_reg, fall_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            prev_reg  <= 1'b0;
            rise_reg  <= 1'b0;
            fall_reg  <= 1'b0;
        end else begin
            sync1_reg <= din;
            sync2_reg <= sync1_reg;
            prev_reg  <= sync2_reg;
            rise_reg  <= sync2_reg & ~prev_reg;
            fall_reg  <= ~sync2_reg & prev_reg;
        end
    end

    assign rise = rise_reg;
    assign fall = fall_reg;

endmodule

// File: rtl/adsr_envelope_seq.sv
// ADSR envelope sequencer: one phase FSM plus the envelope register, advanced by
// per-phase rate strobes and steered by the synchronized gate edges.
module adsr_envelope_seq
    import adsr_pkg::*;
#(
    parameter int ATTACK_STEP  = 8,
    parameter int DECAY_STEP   = 4,
    parameter int RELEASE_STEP = 4
) (
    input  logic             clk50Mhz,
    input  logic             Reset,
    input  logic             GATE,
    input  logic             TICK_A,
    input  logic             TICK_D,
    input  logic             TICK_R,
    input  logic [3:0]       SUS_LEVEL,
    output logic [ENV_W-1:0] ENV,
    output logic [2:0]       STATE,
    output logic             ACTIVE,
    output logic             DONE
);

    localparam logic [ENV_W:0] A_STEP = (ENV_W+1)'(ATTACK_STEP);
    localparam logic [ENV_W:0] D_STEP = (ENV_W+1)'(DECAY_STEP);
    localparam logic [ENV_W:0] R_STEP = (ENV_W+1)'(RELEASE_STEP);
    localparam logic [ENV_W:0] FULL   = {1'b0, ENV_MAX};

    state_t           state_reg, state_next;
    logic [ENV_W-1:0] env_reg, env_next;
    logic             done_reg, done_next;
    logic             gate_rise, gate_fall;
    logic [ENV_W:0]   target, env_wide, attack_sum, decay_diff, release_diff;

    gate_sync u_gate_sync (
        .clk  (clk50Mhz),
        .rst  (Reset),
        .din  (GATE),
        .rise (gate_rise),
        .fall (gate_fall)
    );

    assign target       = sus_target(SUS_LEVEL);
    assign env_wide     = {1'b0, env_reg};
    assign attack_sum   = env_wide + A_STEP;
    assign decay_diff   = env_wide - D_STEP;
    assign release_diff = env_wide - R_STEP;

    always_ff @(posedge clk50Mhz or posedge Reset) begin
        if (Reset) begin
            state_reg <= ST_IDLE;
            env_reg   <= '0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            env_reg   <= env_next;
            done_reg  <= done_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        env_next   = env_reg;
        done_next  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                env_next = '0;
                if (gate_rise) state_next = ST_ATTACK;
            end
            ST_ATTACK, ST_DECAY, ST_SUSTAIN, ST_RELEASE: begin
                // Gate edges pre-empt any tick; the level is kept so a retrigger never clicks.
                if (gate_rise) begin
                    state_next = ST_ATTACK;
                end else if (gate_fall && state_reg != ST_RELEASE) begin
                    state_next = ST_RELEASE;
                end else begin
                    case (state_reg)
                        ST_ATTACK: begin
                            if (TICK_A) begin
                                if (attack_sum >= FULL) begin
                                    env_next   = ENV_MAX;
                                    state_next = ST_DECAY;
                                end else begin
                                    env_next = ENV_W'(attack_sum);
                                end
                            end
                        end
                        ST_DECAY: begin
                            // Difference form avoids overflowing target + step.
                            if (env_wide <= target ||
                                (TICK_D && (env_wide - target) <= D_STEP)) begin
                                env_next   = ENV_W'(target);
                                state_next = ST_SUSTAIN;
                            end else if (TICK_D) begin
                                env_next = ENV_W'(decay_diff);
                            end
                        end
                        ST_SUSTAIN: begin
                            env_next = ENV_W'(target);
                        end
                        default: begin
                            if (TICK_R) begin
                                if (env_wide <= R_STEP) begin
                                    env_next   = '0;
                                    state_next = ST_IDLE;
                                    done_next  = 1'b1;
                                end else begin
                                    env_next = ENV_W'(release_diff);
                                end
                            end
                        end
                    endcase
                end
            end
            default: begin
                state_next = ST_IDLE;
                env_next   = '0;
            end
        endcase
    end

    assign ENV    = env_reg;
    assign STATE  = state_reg;
    assign ACTIVE = (state_reg != ST_IDLE);
    assign DONE   = done_reg;

endmodule
